// File: rtl/imem_arbiter.sv
// Shares the single instruction-memory read port between fetch and the loader.
// Fetch has fixed priority; a loader denied MAX_WAIT cycles in a row gets forced priority.
module imem_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [DATA_W-1:0] f_rdata_o,
    input  logic              l_req_i,
    input  logic [ADDR_W-1:0] l_addr_i,
    output logic              l_gnt_o,
    output logic              l_rvalid_o,
    output logic [DATA_W-1:0] l_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    typedef enum logic [1:0] {StIdle, StFOwn, StLOwn} state_e;

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    state_e            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic              force_l;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            addr_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_hold_q <= addr_hold_d;
        end
    end

    // Grants depend only on requests and registered state, never on mem_data_i.
    assign force_l = (wait_cnt_q == MaxWait);

    always_comb begin
        l_gnt_o = l_req_i & (force_l | ~f_req_i);
        f_gnt_o = f_req_i & ~l_gnt_o;
    end

    always_comb begin
        state_d     = StIdle;
        wait_cnt_d  = wait_cnt_q;
        addr_hold_d = addr_hold_q;

        if (f_gnt_o) begin
            state_d     = StFOwn;
            addr_hold_d = f_addr_i;
        end else if (l_gnt_o) begin
            state_d     = StLOwn;
            addr_hold_d = l_addr_i;
        end

        if (l_gnt_o || !l_req_i) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < MaxWait) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_comb begin
        f_rvalid_o = 1'b0;
        l_rvalid_o = 1'b0;
        unique case (state_q)
            StFOwn:  f_rvalid_o = 1'b1;
            StLOwn:  l_rvalid_o = 1'b1;
            default: ;
        endcase

        f_rdata_o = f_rvalid_o ? mem_data_i : '0;
        l_rdata_o = l_rvalid_o ? mem_data_i : '0;

        if (f_gnt_o) begin
            mem_addr_o = f_addr_i;
        end else if (l_gnt_o) begin
            mem_addr_o = l_addr_i;
        end else begin
            mem_addr_o = addr_hold_q;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vector table, reset corner sequences, and random
// traffic checked against a queue-style model of the arbitration rules.
module tb_imem_arbiter;

    localparam int MaxWait = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, l_req;
    logic [11:0] f_addr, l_addr;
    logic        f_gnt, l_gnt, f_rvalid, l_rvalid;
    logic [31:0] f_rdata, l_rdata, mem_data;
    logic [11:0] mem_addr;

    logic [31:0] mem [4096];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instruction memory: synchronous read, output cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mem_data <= '0;
        else       mem_data <= mem[mem_addr];
    end

    imem_arbiter #(
        .ADDR_W  (12),
        .DATA_W  (32),
        .MAX_WAIT(MaxWait)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req_i   (f_req),
        .f_addr_i  (f_addr),
        .f_gnt_o   (f_gnt),
        .f_rvalid_o(f_rvalid),
        .f_rdata_o (f_rdata),
        .l_req_i   (l_req),
        .l_addr_i  (l_addr),
        .l_gnt_o   (l_gnt),
        .l_rvalid_o(l_rvalid),
        .l_rdata_o (l_rdata),
        .mem_addr_o(mem_addr),
        .mem_data_i(mem_data)
    );

    typedef struct {
        logic        fr;
        logic [11:0] fa;
        logic        lr;
        logic [11:0] la;
        logic        fg;
        logic        lg;
        logic [11:0] ma;
        logic        frv;
        logic        lrv;
        logic [31:0] d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic fr, logic [11:0] fa, logic lr, logic [11:0] la,
                               logic fg, logic lg, logic [11:0] ma,
                               logic frv, logic lrv, logic [31:0] d);
        vec_t r;
        r.fr = fr; r.fa = fa; r.lr = lr; r.la = la;
        r.fg = fg; r.lg = lg; r.ma = ma; r.frv = frv; r.lrv = lrv; r.d = d;
        return r;
    endfunction

    function automatic logic [79:0] obs();
        return {f_gnt, l_gnt, f_rvalid, l_rvalid, mem_addr, f_rdata, l_rdata};
    endfunction

    function automatic logic [79:0] pack_exp(logic fg, logic lg, logic frv, logic lrv,
                                             logic [11:0] ma, logic [31:0] d);
        return {fg, lg, frv, lrv, ma, (frv ? d : 32'h0), (lrv ? d : 32'h0)};
    endfunction

    task automatic check(string name, logic [79:0] act, logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {fg,lg,frv,lrv,addr,frd,lrd}=%h expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic drive(logic fr, logic [11:0] fa, logic lr, logic [11:0] la);
        @(negedge clk);
        f_req = fr; f_addr = fa; l_req = lr; l_addr = la;
        #1;
    endtask

    // Model state: denial streak, response owed next cycle, last granted address.
    int          streak;
    bit          pend_v, pend_f;
    logic [11:0] pend_a, last_a;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
        mem[12'hFFF] = 32'hDEAD_BEEF;

        reset = 1'b1;
        f_req = 0; l_req = 0; f_addr = '0; l_addr = '0;
        @(negedge clk);
        #1;
        check("in_reset", obs(), 80'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0);
            check($sformatf("idle_%0d", i), obs(), 80'h0);
        end

        tbl.push_back(v(1, 12'h000, 0, 0,       1, 0, 12'h000, 0, 0, 0));
        tbl.push_back(v(1, 12'h001, 0, 0,       1, 0, 12'h001, 1, 0, 32'h1000_0000));
        tbl.push_back(v(1, 12'h002, 0, 0,       1, 0, 12'h002, 1, 0, 32'h1000_0001));
        tbl.push_back(v(1, 12'h003, 0, 0,       1, 0, 12'h003, 1, 0, 32'h1000_0002));
        tbl.push_back(v(0, 0,       0, 0,       0, 0, 12'h003, 1, 0, 32'h1000_0003));
        tbl.push_back(v(0, 0,       1, 12'hFFF, 0, 1, 12'hFFF, 0, 0, 0));
        tbl.push_back(v(0, 0,       0, 0,       0, 0, 12'hFFF, 0, 1, 32'hDEAD_BEEF));
        tbl.push_back(v(0, 0,       0, 0,       0, 0, 12'hFFF, 0, 0, 0));
        tbl.push_back(v(1, 12'h010, 0, 0,       1, 0, 12'h010, 0, 0, 0));
        tbl.push_back(v(0, 0,       1, 12'h020, 0, 1, 12'h020, 1, 0, 32'h1000_0010));
        tbl.push_back(v(1, 12'h030, 0, 0,       1, 0, 12'h030, 0, 1, 32'h1000_0020));
        tbl.push_back(v(0, 0,       0, 0,       0, 0, 12'h030, 1, 0, 32'h1000_0030));
        // Both requesting: F,F,F,F,L twice.
        tbl.push_back(v(1, 12'h100, 1, 12'h200, 1, 0, 12'h100, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(1, 12'h100, 1, 12'h200, 1, 0, 12'h100, 1, 0, 32'h1000_0100));
        tbl.push_back(v(1, 12'h100, 1, 12'h200, 0, 1, 12'h200, 1, 0, 32'h1000_0100));
        tbl.push_back(v(1, 12'h100, 1, 12'h200, 1, 0, 12'h100, 0, 1, 32'h1000_0200));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(1, 12'h100, 1, 12'h200, 1, 0, 12'h100, 1, 0, 32'h1000_0100));
        tbl.push_back(v(1, 12'h100, 1, 12'h200, 0, 1, 12'h200, 1, 0, 32'h1000_0100));
        // Loader denied twice, drops, re-raises: needs four fresh denials.
        tbl.push_back(v(1, 12'h100, 1, 12'h200, 1, 0, 12'h100, 0, 1, 32'h1000_0200));
        tbl.push_back(v(1, 12'h100, 1, 12'h200, 1, 0, 12'h100, 1, 0, 32'h1000_0100));
        tbl.push_back(v(1, 12'h100, 0, 12'h200, 1, 0, 12'h100, 1, 0, 32'h1000_0100));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(1, 12'h100, 1, 12'h200, 1, 0, 12'h100, 1, 0, 32'h1000_0100));
        tbl.push_back(v(1, 12'h100, 1, 12'h200, 0, 1, 12'h200, 1, 0, 32'h1000_0100));
        tbl.push_back(v(0, 0,       0, 0,       0, 0, 12'h200, 0, 1, 32'h1000_0200));

        foreach (tbl[i]) begin
            drive(tbl[i].fr, tbl[i].fa, tbl[i].lr, tbl[i].la);
            check($sformatf("row_%0d", i), obs(),
                  pack_exp(tbl[i].fg, tbl[i].lg, tbl[i].frv, tbl[i].lrv, tbl[i].ma, tbl[i].d));
        end

        // Reset with a fetch read in flight.
        drive(1, 12'h077, 0, 0);
        check("mid_grant", obs(), pack_exp(1, 0, 0, 0, 12'h077, 0));
        drive(0, 0, 0, 0);
        check("mid_resp", obs(), pack_exp(0, 0, 1, 0, 12'h077, 32'h1000_0077));
        reset = 1'b1;
        #1;
        check("mid_reset_drop", obs(), 80'h0);
        @(negedge clk);
        reset = 1'b0;
        f_req = 1; f_addr = 12'h055;
        #1;
        check("post_reset_first", obs(), pack_exp(1, 0, 0, 0, 12'h055, 0));

        streak = 0; pend_v = 1; pend_f = 1; pend_a = 12'h055; last_a = 12'h055;
        for (int c = 0; c < 1500; c++) begin
            logic fr, lr, fg, lg;
            logic [11:0] fa, la, ea;
            fr = ($urandom_range(0, 3) != 0);
            lr = ($urandom_range(0, 2) != 0);
            fa = 12'($urandom);
            la = 12'($urandom);
            drive(fr, fa, lr, la);
            // Loader wins when fetch is absent or the loader is owed its turn.
            lg = lr && (!fr || streak >= MaxWait);
            fg = fr && !lg;
            ea = fg ? fa : (lg ? la : last_a);
            check($sformatf("rand_%0d", c), obs(),
                  pack_exp(fg, lg, pend_v && pend_f, pend_v && !pend_f, ea, mem[pend_a]));
            if (!lr || lg) streak = 0;
            else if (streak < MaxWait) streak++;
            pend_v = fg || lg;
            pend_f = fg;
            pend_a = ea;
            last_a = ea;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter in front of the single-read-port instruction memory (4096 x 32-bit words, synchronous read, one-cycle latency, output cleared by reset). It shares that port between the core's fetch stage and the debug/program-loader read port. Fetch has fixed priority, with a bounded-starvation override for the loader. It also tracks the in-flight read and routes the returned word, tagged by owner, back to the requester that issued it.

## Interface
Parameters:
- ADDR_W, 12, word address width; matches instruction memory depth 4096.
- DATA_W, 32, instruction word width.
- MAX_WAIT, 4, consecutive denied loader-request cycles before the loader is forced priority; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- f_req  in  1  fetch requests a read this cycle.
- f_addr  in  ADDR_W  fetch word address.
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_rvalid  out  1  f_rdata valid (registered owner tag).
- f_rdata  out  DATA_W  returned instruction for fetch.
- l_req  in  1  loader requests a read this cycle.
- l_addr  in  ADDR_W  loader word address.
- l_gnt  out  1  loader request accepted this cycle (combinational).
- l_rvalid  out  1  l_rdata valid.
- l_rdata  out  DATA_W  returned word for loader.
- mem_addr  out  ADDR_W  address to instruction memory (combinational mux over held register).
- mem_data  in  DATA_W  instruction memory read data, valid one cycle after address sampled.

## Operation
- Owner state register, states: IDLE (no read in flight), F_OWN (fetch read in flight), L_OWN (loader read in flight). Next state each cycle: F_OWN if f_gnt, L_OWN if l_gnt, else IDLE. One grant per cycle; a new grant may issue every cycle (fully pipelined, no bubbles).
- Arbitration, same cycle as request:
  - force = (wait_cnt == MAX_WAIT).
  - l_gnt = l_req & (force | ~f_req); f_gnt = f_req & ~l_gnt.
  - Neither requesting: no grant.
- wait_cnt (4-bit):
  - Increments when l_req & ~l_gnt, saturating at MAX_WAIT.
  - Clears to 0 when l_gnt or ~l_req.
- mem_addr: f_addr when f_gnt, l_addr when l_gnt, otherwise the last granted address (addr_hold register, updated on every grant).
- Response routing:
  - f_rvalid = (state == F_OWN); l_rvalid = (state == L_OWN).
  - f_rdata = mem_data when f_rvalid, else 0; l_rdata = mem_data when l_rvalid, else 0.
- Responses cannot be back-pressured; a requester must accept rvalid in the cycle it is asserted.
- Requester holds req/addr stable until it sees gnt; an address change while ungranted is legal and takes effect immediately.

## Timing
- Reset values: state IDLE, wait_cnt 0, addr_hold 0, hence mem_addr 0 with no req, f_gnt/l_gnt 0 with no req, f_rvalid 0, l_rvalid 0, f_rdata 0, l_rdata 0.
- Latency: request granted in cycle N (address sampled at edge ending N); rvalid and rdata in cycle N+1. Back-to-back grants N, N+1 give responses N+1, N+2.
- Simultaneous f_req & l_req with wait_cnt < MAX_WAIT: fetch wins, wait_cnt++.
- Loader blocked MAX_WAIT consecutive cycles: the next cycle l_gnt=1, f_gnt=0 regardless of f_req; wait_cnt then returns to 0. Worst-case loader wait is MAX_WAIT+1 cycles.
- Reset asserted mid-flight: in-flight response dropped (rvalid low immediately, async), wait_cnt cleared. Memory output is also cleared by the same reset, so no stale word is presented.
- First cycle after reset release: no rvalid, even if a request is granted in that cycle.
- gnt is combinational from req and registered state only; no combinational path from mem_data to gnt.

## Test plan
- Reset then idle: all outputs 0, mem_addr 0 for 5 cycles; assert reset mid-run with an F_OWN read in flight -> f_rvalid drops the same cycle.
- Fetch-only stream, f_addr 0,1,2,3 on consecutive cycles, memory preloaded word[i] = 0x1000_0000+i -> f_gnt high every cycle; f_rvalid cycles 2..5 with f_rdata 0x10000000..0x10000003; l_rvalid never high.
- Loader-only single read, l_addr 0xFFF (wrap boundary), word = 0xDEADBEEF -> l_gnt same cycle, l_rvalid next cycle with l_rdata 0xDEADBEEF; state returns to IDLE.
- Both requesting continuously, MAX_WAIT=4 -> fetch granted 4 cycles, loader granted 5th cycle, repeating pattern F,F,F,F,L.
- Loader drops l_req after 2 denied cycles then re-raises -> wait_cnt restarts at 0; loader needs 4 more denied cycles before forced grant.
- Alternating grants F(addr 0x010), L(addr 0x020), F(addr 0x030) back-to-back -> f_rvalid, l_rvalid, f_rvalid on successive cycles, each with its own word and no cross-delivery.
